// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle between the AHB masters and the bus arbiter.
// The arbiter connects through the slave modport; the bus-master side uses master.
interface ahb_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 3
) ();
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic                   hresp;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [1:0]             hmaster;
    logic                   hmastlock;

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with burst tracking, locked transfers and a default master 0.
// Grants only change at accepted beats that end a burst (or in idle arbitration).
module ahb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 3
) (
    input logic               hclk,
    input logic               reset,
    ahb_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StArb, StBurst, StIncr} state_e;

    localparam logic [1:0] TrIdle = 2'b00;
    localparam logic [1:0] TrBusy = 2'b01;
    localparam logic [1:0] TrNseq = 2'b10;
    localparam logic [1:0] TrSeq  = 2'b11;

    state_e                 state_q, state_d;
    logic [3:0]             beats_left_q, beats_left_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [1:0]             grant_idx_q, grant_idx_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [1:0]             hmaster_q;
    logic                   hmastlock_q;

    logic                   owner_req, owner_lock;
    logic                   rearb;
    logic                   win_found;
    logic [1:0]             win;
    logic [2:0]             cand;
    logic [3:0]             fixed_len;
    state_e                 start_state;
    logic [3:0]             start_left;

    // The owner is the currently granted master; its request/lock drive burst end and hold.
    assign owner_req  = bus.hbusreq[grant_idx_q];
    assign owner_lock = bus.hlock[grant_idx_q];

    // Outcome of a NON_SEQ starting a new transfer, whatever state we are in.
    always_comb begin
        fixed_len = 4'd0;
        case (bus.hburst[2:1])
            2'b01:   fixed_len = 4'd3;
            2'b10:   fixed_len = 4'd7;
            2'b11:   fixed_len = 4'd15;
            default: fixed_len = 4'd0;
        endcase
        start_state = StArb;
        start_left  = 4'd0;
        if (bus.htrans == TrNseq) begin
            if (bus.hburst[2:1] != 2'b00) begin
                start_state = StBurst;
                start_left  = fixed_len;
            end else if (bus.hburst[0]) begin
                start_state = StIncr;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        rearb        = 1'b0;
        if (bus.hready) begin
            case (state_q)
                StArb: begin
                    state_d      = start_state;
                    beats_left_d = start_left;
                end
                StBurst: begin
                    if (bus.hresp) begin
                        state_d      = StArb;
                        beats_left_d = 4'd0;
                    end else begin
                        case (bus.htrans)
                            TrSeq: begin
                                if (beats_left_q <= 4'd1) begin
                                    state_d      = StArb;
                                    beats_left_d = 4'd0;
                                end else begin
                                    beats_left_d = beats_left_q - 4'd1;
                                end
                            end
                            TrBusy: ;
                            TrIdle: begin
                                state_d      = StArb;
                                beats_left_d = 4'd0;
                            end
                            default: begin
                                state_d      = start_state;
                                beats_left_d = start_left;
                            end
                        endcase
                    end
                end
                StIncr: begin
                    if (bus.hresp) begin
                        state_d      = StArb;
                        beats_left_d = 4'd0;
                    end else if (!owner_req) begin
                        state_d = StArb;
                    end
                end
                default: begin
                    state_d      = StArb;
                    beats_left_d = 4'd0;
                end
            endcase
            rearb = (state_d == StArb) && !owner_lock;
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        win_found = 1'b0;
        win       = 2'd0;
        cand      = 3'd0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_ptr_q} + 3'(i);
            if (cand >= 3'(NUM_MASTERS)) begin
                cand = cand - 3'(NUM_MASTERS);
            end
            if (!win_found && bus.hbusreq[cand[1:0]]) begin
                win_found = 1'b1;
                win       = cand[1:0];
            end
        end
    end

    always_comb begin
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (rearb) begin
            if (win_found) begin
                grant_idx_d = win;
                rr_ptr_d    = (win == 2'(NUM_MASTERS - 1)) ? 2'd0 : win + 2'd1;
            end else begin
                grant_idx_d = 2'd0;
            end
        end
        grant_d = NUM_MASTERS'(1) << grant_idx_d;
    end

    always_ff @(posedge hclk or negedge reset) begin
        if (!reset) begin
            state_q      <= StArb;
            beats_left_q <= 4'd0;
            rr_ptr_q     <= 2'd1;
            grant_idx_q  <= 2'd0;
            grant_q      <= NUM_MASTERS'(1);
            hmaster_q    <= 2'd0;
            hmastlock_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            grant_q      <= grant_d;
            if (bus.hready) begin
                hmaster_q   <= grant_idx_q;
                hmastlock_q <= owner_lock;
            end
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each bus scenario.
module tb_ahb_bus_arbiter;
    localparam int N = 3;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    logic hclk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .hclk  (hclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 hclk = ~hclk;

    // Model state: who holds the bus, what last owned the address phase, and how
    // much of the current burst remains (mode 0 none, 1 counted, 2 open-ended).
    typedef struct {
        int grant;
        int master;
        bit lock;
        int rr;
        int left;
        int mode;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.grant = 0; r.master = 0; r.lock = 0; r.rr = 1; r.left = 0; r.mode = 0;
        return r;
    endfunction

    // Total beats for a burst code; 0 means undefined length.
    function automatic int burst_beats(logic [2:0] b);
        if (b == 3'b000) return 1;
        if (b == 3'b001) return 0;
        if (b[2:1] == 2'b01) return 4;
        if (b[2:1] == 2'b10) return 8;
        return 16;
    endfunction

    function automatic mdl_t step(mdl_t s, logic [N-1:0] req, logic [N-1:0] lck,
                                  logic [1:0] tr, logic [2:0] bu, logic resp);
        mdl_t n     = s;
        bit   done  = 0;
        int   owner = s.grant;
        int   len;
        if (s.mode != 0 && resp) begin
            n.mode = 0; n.left = 0; done = 1;
        end else if (s.mode == 2) begin
            if (!req[owner]) begin n.mode = 0; done = 1; end
        end else if (s.mode == 1 && tr == SEQ) begin
            n.left = s.left - 1;
            if (n.left == 0) begin n.mode = 0; done = 1; end
        end else if (s.mode == 1 && tr == BUSY) begin
            done = 0;
        end else begin
            n.mode = 0; n.left = 0; done = 1;
            if (tr == NSEQ) begin
                len = burst_beats(bu);
                if (len == 0) begin n.mode = 2; done = 0; end
                else if (len > 1) begin n.mode = 1; n.left = len - 1; done = 0; end
            end
        end
        n.master = owner;
        n.lock   = lck[owner];
        if (done && !lck[owner]) begin
            n.grant = 0;
            for (int i = 0; i < N; i++) begin
                int k = (s.rr + i) % N;
                if (req[k]) begin
                    n.grant = k;
                    n.rr    = (k + 1) % N;
                    break;
                end
            end
        end
        return n;
    endfunction

    always @(posedge hclk or negedge reset) begin
        if (!reset) mdl <= mdl_reset();
        else if (bus.hready)
            mdl <= step(mdl, bus.hbusreq, bus.hlock, bus.htrans, bus.hburst, bus.hresp);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge hclk) begin
        logic [N-1:0] exp_grant;
        exp_grant = N'(1) << mdl.grant;
        check("model_hgrant", 32'(bus.hgrant), 32'(exp_grant));
        check("model_hmaster", 32'(bus.hmaster), 32'(mdl.master));
        check("model_hmastlock", 32'(bus.hmastlock), 32'(mdl.lock));
        check("onehot_hgrant", 32'($onehot(bus.hgrant)), 32'd1);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.htrans  = IDLE;
        bus.hburst  = 3'b000;
        bus.hready  = 1'b1;
        bus.hresp   = 1'b0;
        cyc(2);
        check("rst_hgrant", 32'(bus.hgrant), 32'h1);
        check("rst_hmaster", 32'(bus.hmaster), 32'h0);
        check("rst_hmastlock", 32'(bus.hmastlock), 32'h0);

        // Scenario 1: no requests keeps the default master.
        reset = 1'b1;
        cyc(4);
        check("s1_hgrant", 32'(bus.hgrant), 32'h1);
        check("s1_hmaster", 32'(bus.hmaster), 32'h0);

        // Scenario 2: masters 1 and 2 alternate on single transfers.
        bus.hbusreq = 3'b110; bus.htrans = NSEQ; bus.hburst = 3'b000;
        cyc(); check("s2_g1", 32'(bus.hgrant), 32'h2);
        cyc(); check("s2_g2", 32'(bus.hgrant), 32'h4);
        check("s2_m2", 32'(bus.hmaster), 32'h1);
        cyc(); check("s2_g3", 32'(bus.hgrant), 32'h2);
        check("s2_m3", 32'(bus.hmaster), 32'h2);
        cyc(); check("s2_g4", 32'(bus.hgrant), 32'h4);

        // Scenario 3: master 2 INCR8 with a BUSY and two wait states.
        bus.hbusreq = 3'b101; bus.hburst = 3'b101; bus.htrans = NSEQ;
        cyc(); check("s3_nseq", 32'(bus.hgrant), 32'h4);
        check("s3_hmaster", 32'(bus.hmaster), 32'h2);
        bus.htrans = SEQ; cyc(3);
        bus.htrans = BUSY; cyc();
        bus.htrans = SEQ; bus.hready = 1'b0; cyc(2);
        check("s3_wait", 32'(bus.hgrant), 32'h4);
        bus.hready = 1'b1; cyc(3);
        check("s3_beat7", 32'(bus.hgrant), 32'h4);
        cyc(); check("s3_beat8", 32'(bus.hgrant), 32'h1);

        // Scenario 4: INCR4 cut short by IDLE after beat 2.
        bus.hburst = 3'b011; bus.htrans = NSEQ;
        cyc(); check("s4_beat1", 32'(bus.hgrant), 32'h1);
        bus.htrans = SEQ; cyc(); check("s4_beat2", 32'(bus.hgrant), 32'h1);
        bus.htrans = IDLE; cyc(); check("s4_idle", 32'(bus.hgrant), 32'h4);

        // Scenario 5: master 1 locked across three single transfers.
        bus.hbusreq = 3'b010; cyc(); check("s5_pre", 32'(bus.hgrant), 32'h2);
        bus.hlock = 3'b010; bus.hbusreq = 3'b111; bus.htrans = NSEQ; bus.hburst = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("s5_lock_grant", 32'(bus.hgrant), 32'h2);
            check("s5_mastlock", 32'(bus.hmastlock), 32'h1);
        end
        bus.hlock = 3'b000; cyc();
        check("s5_release", 32'(bus.hgrant), 32'h4);
        check("s5_mastlock_off", 32'(bus.hmastlock), 32'h0);

        // Scenario 6: ERROR on beat 3 of INCR16, then reset during a second INCR16.
        bus.hbusreq = 3'b101; bus.hburst = 3'b111; bus.htrans = NSEQ;
        cyc(); bus.htrans = SEQ; cyc();
        check("s6_beat2", 32'(bus.hgrant), 32'h4);
        bus.hresp = 1'b1; bus.hbusreq = 3'b010; cyc();
        check("s6_err_rearb", 32'(bus.hgrant), 32'h2);
        bus.hresp = 1'b0; bus.htrans = NSEQ; cyc();
        bus.htrans = SEQ; cyc(3);
        check("s6_beat4_grant", 32'(bus.hgrant), 32'h2);
        check("s6_beat4_master", 32'(bus.hmaster), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("s6_async_hgrant", 32'(bus.hgrant), 32'h1);
        check("s6_async_hmaster", 32'(bus.hmaster), 32'h0);
        check("s6_async_lock", 32'(bus.hmastlock), 32'h0);
        cyc();
        reset = 1'b1; bus.hbusreq = 3'b111; bus.htrans = IDLE;
        cyc(); check("s6_post_rr", 32'(bus.hgrant), 32'h2);
        check("s6_post_master", 32'(bus.hmaster), 32'h0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
